barrel_scheduler: RTL and testbench

BARREL_SCHEDULER -- requirements
Module: barrel_scheduler

---
 rtl/barrel_pkg.sv | 29 ++
 rtl/barrel_scheduler_lowest_free_sel.sv | 16 +
 rtl/barrel_scheduler.sv | 100 ++++++++++
 tb/tb_barrel_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared constants and FSM state type for the barrel spawn scheduler and barrel instances.
package barrel_pkg;

  localparam int unsigned NUM_BARRELS    = 4;
  localparam int unsigned START_INTERVAL = 120;
  localparam int unsigned MIN_INTERVAL   = 40;
  localparam int unsigned INTERVAL_STEP  = 8;
  localparam int unsigned STEP_EVERY     = 4;
  localparam int unsigned TIMER_W        = 10;
  localparam int unsigned COUNT_W        = 4;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_PAUSED    = 2'd2
  } sched_state_t;

  // Interval after one difficulty step, clamped at the floor (compare in 11 bits to avoid wrap).
  function automatic logic [TIMER_W-1:0] next_interval(
    input logic [TIMER_W-1:0] cur,
    input logic [TIMER_W-1:0] step,
    input logic [TIMER_W-1:0] floor_v
  );
    if ({1'b0, cur} >= ({1'b0, floor_v} + {1'b0, step}))
      return cur - step;
    return floor_v;
  endfunction

endpackage

// File: rtl/barrel_scheduler_lowest_free_sel.sv
// Lowest-index free slot picker: one-hot grant of the least significant set bit of free.
module lowest_free_sel
  import barrel_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] free,
  output logic [N-1:0] grant,
  output logic         valid
);

  // Two's-complement isolate of the lowest set bit.
  assign grant = free & ((~free) + N'(1));
  assign valid = |free;

endmodule

// File: rtl/barrel_scheduler.sv
// Frame-paced barrel spawn scheduler: timed spawns into free slots, difficulty ramp, pause/restart.
module barrel_scheduler #(
  parameter int unsigned NUM_BARRELS    = barrel_pkg::NUM_BARRELS,
  parameter int unsigned START_INTERVAL = barrel_pkg::START_INTERVAL,
  parameter int unsigned MIN_INTERVAL   = barrel_pkg::MIN_INTERVAL,
  parameter int unsigned INTERVAL_STEP  = barrel_pkg::INTERVAL_STEP,
  parameter int unsigned STEP_EVERY     = barrel_pkg::STEP_EVERY
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   pause,
  input  logic                   enter,
  input  logic [NUM_BARRELS-1:0] despawn,
  output logic [NUM_BARRELS-1:0] spawn,
  output logic [NUM_BARRELS-1:0] active,
  output logic [3:0]             active_count,
  output logic [9:0]             interval
);

  import barrel_pkg::*;

  localparam logic [9:0] START_I  = 10'(START_INTERVAL);
  localparam logic [9:0] START_T  = 10'(START_INTERVAL - 1);
  localparam logic [9:0] MIN_I    = 10'(MIN_INTERVAL);
  localparam logic [9:0] STEP_I   = 10'(INTERVAL_STEP);
  localparam logic [2:0] CNT_LAST = 3'(STEP_EVERY - 1);

  sched_state_t           state;
  logic [9:0]             timer;
  logic [2:0]             spawn_cnt;
  logic [NUM_BARRELS-1:0] free_mask;
  logic [NUM_BARRELS-1:0] grant;
  logic                   free_valid;
  logic                   due;
  logic                   do_spawn;

  assign free_mask = ~active;

  lowest_free_sel #(
    .N(NUM_BARRELS)
  ) u_sel (
    .free  (free_mask),
    .grant (grant),
    .valid (free_valid)
  );

  // Leaving PAUSED with pause low schedules in that same cycle, so the held timer resumes without a lost frame.
  assign due      = (state == ST_WAIT_SLOT) || (timer == '0);
  assign do_spawn = !pause && due && free_valid;

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < NUM_BARRELS; i++)
      active_count = active_count + 4'(active[i]);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_RUN;
      timer     <= START_T;
      interval  <= START_I;
      spawn_cnt <= '0;
      active    <= '0;
      spawn     <= '0;
    end else begin
      spawn <= '0;
      if (pause) begin
        state <= ST_PAUSED;
        if (state == ST_PAUSED && enter) begin
          active    <= '0;
          interval  <= START_I;
          timer     <= START_T;
          spawn_cnt <= '0;
        end
      end else begin
        active <= (active & ~despawn) | (grant & {NUM_BARRELS{do_spawn}});
        if (due) begin
          if (free_valid) begin
            spawn <= grant;
            timer <= interval - 10'd1;
            state <= ST_RUN;
            if (spawn_cnt == CNT_LAST) begin
              spawn_cnt <= '0;
              interval  <= next_interval(interval, STEP_I, MIN_I);
            end else begin
              spawn_cnt <= spawn_cnt + 3'd1;
            end
          end else begin
            timer <= '0;
            state <= ST_WAIT_SLOT;
          end
        end else begin
          timer <= timer - 10'd1;
          state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Self-checking bench for barrel_scheduler: directed vector table, corner sequences, randomized model compare.
module tb_barrel_scheduler;

  localparam int START = 120;
  localparam int MINI  = 40;
  localparam int STEPI = 8;
  localparam int EVERY = 4;

  logic       frame_clk;
  logic       Reset;
  logic       pause;
  logic       enter;
  logic [3:0] despawn;
  logic [3:0] spawn;
  logic [3:0] active;
  logic [3:0] active_count;
  logic [9:0] interval;

  int n_pass;
  int n_total;

  barrel_scheduler #(
    .NUM_BARRELS   (4),
    .START_INTERVAL(START),
    .MIN_INTERVAL  (MINI),
    .INTERVAL_STEP (STEPI),
    .STEP_EVERY    (EVERY)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .pause       (pause),
    .enter       (enter),
    .despawn     (despawn),
    .spawn       (spawn),
    .active      (active),
    .active_count(active_count),
    .interval    (interval)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int         n;
    logic [3:0] desp;
    logic [3:0] exp_spawn;
    logic [3:0] exp_act;
    int         exp_cnt;
    int         exp_int;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic int exp_interval(input int spawns);
    int v;
    v = START - STEPI * (spawns / EVERY);
    return (v < MINI) ? MINI : v;
  endfunction

  task automatic do_reset();
    pause   = 1'b0;
    enter   = 1'b0;
    despawn = '0;
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    chk("rst_spawn", int'(spawn), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_count", int'(active_count), 0);
    chk("rst_interval", int'(interval), START);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic wait_spawn(input int limit, output int edges, output logic [3:0] s);
    edges = 0;
    s     = '0;
    while (edges < limit) begin
      step();
      edges++;
      if (spawn != '0) begin
        s = spawn;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Behavioural reference state
  int       m_wait;
  bit [3:0] m_act;
  int       m_spawns;
  bit       m_paused;

  initial begin
    vec_t       vt[12];
    int         edges;
    logic [3:0] s;
    bit         saw;
    int         pause_left;
    bit [3:0]   e_spawn;
    bit [3:0]   d;
    bit         p;
    bit         e;

    n_pass  = 0;
    n_total = 0;
    Reset   = 1'b1;
    pause   = 1'b0;
    enter   = 1'b0;
    despawn = '0;

    // Edge-numbered trace from reset: fill the four slots, stall in WAIT_SLOT, free one, then a reload check.
    vt[0]  = '{119, 4'b0000, 4'b0000, 4'b0000, 0, 120};
    vt[1]  = '{1,   4'b0000, 4'b0001, 4'b0001, 1, 120};
    vt[2]  = '{1,   4'b0000, 4'b0000, 4'b0001, 1, 120};
    vt[3]  = '{119, 4'b0000, 4'b0010, 4'b0011, 2, 120};
    vt[4]  = '{120, 4'b0000, 4'b0100, 4'b0111, 3, 120};
    vt[5]  = '{120, 4'b0000, 4'b1000, 4'b1111, 4, 112};
    vt[6]  = '{120, 4'b0000, 4'b0000, 4'b1111, 4, 112};
    vt[7]  = '{49,  4'b0000, 4'b0000, 4'b1111, 4, 112};
    vt[8]  = '{1,   4'b0100, 4'b0000, 4'b1011, 3, 112};
    vt[9]  = '{1,   4'b0000, 4'b0100, 4'b1111, 4, 112};
    vt[10] = '{111, 4'b0001, 4'b0000, 4'b1110, 3, 112};
    vt[11] = '{1,   4'b0000, 4'b0001, 4'b1111, 4, 112};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vt[i].n; k++) begin
        despawn = (k == vt[i].n - 1) ? vt[i].desp : 4'b0000;
        step();
      end
      despawn = '0;
      chk($sformatf("vec%0d_spawn", i), int'(spawn), int'(vt[i].exp_spawn));
      chk($sformatf("vec%0d_active", i), int'(active), int'(vt[i].exp_act));
      chk($sformatf("vec%0d_count", i), int'(active_count), vt[i].exp_cnt);
      chk($sformatf("vec%0d_interval", i), int'(interval), vt[i].exp_int);
    end

    // Pause at timer=50 for 200 frames, then resume.
    do_reset();
    idle(69);
    pause = 1'b1;
    saw   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (spawn != '0) saw = 1'b1;
    end
    chk("pause_no_spawn", int'(saw), 0);
    pause = 1'b0;
    wait_spawn(300, edges, s);
    chk("pause_resume_edges", edges, 51);
    chk("pause_resume_slot", int'(s), 1);

    // Restart while paused with active=1011; despawn ignored while paused.
    do_reset();
    idle(480);
    despawn = 4'b0100;
    step();
    despawn = '0;
    chk("rst37_active_pre", int'(active), 4'b1011);
    pause = 1'b1;
    step();
    despawn = 4'b0001;
    step();
    despawn = '0;
    chk("paused_despawn_ignored", int'(active), 4'b1011);
    chk("paused_interval_hold", int'(interval), 112);
    enter = 1'b1;
    step();
    enter = 1'b0;
    chk("enter_active", int'(active), 0);
    chk("enter_count", int'(active_count), 0);
    chk("enter_interval", int'(interval), 120);
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (spawn != '0) saw = 1'b1;
    end
    chk("enter_no_spawn", int'(saw), 0);
    pause = 1'b0;
    wait_spawn(300, edges, s);
    chk("enter_release_edges", edges, 120);
    chk("enter_release_slot", int'(s), 1);

    // Asynchronous reset mid-cycle while in WAIT_SLOT with active=0110.
    do_reset();
    idle(599);
    despawn = 4'b1001;
    step();
    despawn = '0;
    chk("wait_active", int'(active), 4'b0110);
    chk("wait_interval", int'(interval), 112);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_spawn", int'(spawn), 0);
    chk("async_rst_count", int'(active_count), 0);
    chk("async_rst_interval", int'(interval), 120);
    #1;
    Reset = 1'b0;
    wait_spawn(300, edges, s);
    chk("post_rst_edges", edges, 120);
    chk("post_rst_slot", int'(s), 1);

    // Difficulty ramp with prompt despawns down to the floor.
    do_reset();
    for (int sp = 1; sp <= 48; sp++) begin
      wait_spawn(200, edges, s);
      chk($sformatf("ramp%0d_found", sp), int'(s), 1);
      chk($sformatf("ramp%0d_interval", sp), int'(interval), exp_interval(sp));
      despawn = s;
      step();
      despawn = '0;
    end

    // Randomized run against the reference model.
    do_reset();
    m_wait     = START - 1;
    m_act      = '0;
    m_spawns   = 0;
    m_paused   = 1'b0;
    pause_left = 0;
    for (int c = 0; c < 6000; c++) begin
      if (pause_left > 0) pause_left--;
      else if ($urandom_range(0, 99) == 0) pause_left = $urandom_range(1, 30);
      p = (pause_left > 0);
      e = p && ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      pause   = p;
      enter   = e;
      despawn = d;
      step();

      e_spawn = '0;
      if (p) begin
        if (m_paused && e) begin
          m_act    = '0;
          m_spawns = 0;
          m_wait   = START - 1;
        end
        m_paused = 1'b1;
      end else begin
        m_paused = 1'b0;
        if (m_wait > 0) begin
          m_wait--;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!m_act[i] && e_spawn == '0) e_spawn[i] = 1'b1;
          end
          if (e_spawn != '0) begin
            m_wait = exp_interval(m_spawns) - 1;
            m_spawns++;
          end
        end
        m_act = (m_act & ~d) | e_spawn;
      end

      chk("rnd_spawn", int'(spawn), int'(e_spawn));
      chk("rnd_active", int'(active), int'(m_act));
      chk("rnd_count", int'(active_count), $countones(m_act));
      chk("rnd_interval", int'(interval), exp_interval(m_spawns));
      chk("rnd_onehot", int'($countones(spawn) <= 1), 1);
    end
    pause   = 1'b0;
    enter   = 1'b0;
    despawn = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
